// File: rtl/gen_clk_pkg.sv
// gen_clk_pkg
// Shared constants and helpers for the gen_clk serial-clock divider.
//   CLK_IN_HZ_DEF : default system clock frequency (Hz)
//   SCL_HZ_DEF    : default divided clock frequency (Hz)
//   calc_half()   : clk_in cycles per clk_out half-period (truncating,
//                   so the divided clock is never slower than requested)
`timescale 1ns/1ps
package gen_clk_pkg;

    localparam int CLK_IN_HZ_DEF = 50_000_000;
    localparam int SCL_HZ_DEF    = 100_000;

    function automatic int calc_half(input int clk_hz, input int scl_hz);
        return clk_hz / (2 * scl_hz);
    endfunction

endpackage

// File: rtl/gen_clk_rst_sync.sv
// gen_clk_rst_sync
// Two-flop reset synchroniser: assertion is asynchronous, release is
// aligned to clk_in so downstream flops never see a release near an edge.
// Ports:
//   clk_in     : system clock
//   resetN     : asynchronous active-low reset from the outside world
//   rst_n_sync : active-low reset, asserted async, deasserted 2 edges later
`timescale 1ns/1ps
module gen_clk_rst_sync (
    input  logic clk_in,
    input  logic resetN,
    output logic rst_n_sync
);

    logic [1:0] sync_reg;

    always_ff @(posedge clk_in or negedge resetN) begin
        if (!resetN) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], 1'b1};
        end
    end

    assign rst_n_sync = sync_reg[1];

endmodule

// File: rtl/gen_clk.sv
// gen_clk
// Divides clk_in down to a 50%-duty serial clock (SCL style) and produces
// single-cycle strobes at each divided-clock edge, so a bus master can run
// entirely on clk_in using the strobes as clock enables.
// Parameters:
//   CLK_IN_HZ : clk_in frequency in Hz
//   SCL_HZ    : requested clk_out frequency in Hz
// Ports:
//   clk_in       : system clock, all logic on its rising edge
//   resetN       : asynchronous active-low reset (release synchronised)
//   clk_out      : divided clock, period 2*HALF clk_in cycles
//   scl_posedge  : high in the first clk_in cycle with clk_out == 1
//   scl_negedge  : high in the first clk_in cycle with clk_out == 0
// Optional (macro GEN_CLK_MID_EN):
//   scl_high_mid : high for one cycle at the centre of each high level
//   scl_low_mid  : high for one cycle at the centre of each low level
`timescale 1ns/1ps
module gen_clk
    import gen_clk_pkg::*;
#(
    parameter int CLK_IN_HZ = CLK_IN_HZ_DEF,
    parameter int SCL_HZ    = SCL_HZ_DEF
) (
    input  logic clk_in,
    input  logic resetN,
    output logic clk_out,
    output logic scl_posedge,
    output logic scl_negedge
`ifdef GEN_CLK_MID_EN
    ,
    output logic scl_high_mid,
    output logic scl_low_mid
`endif
);

    localparam int HALF  = calc_half(CLK_IN_HZ, SCL_HZ);
    localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HALF - 1);

    if (HALF < 2) begin : g_bad_half
        $fatal(1, "gen_clk: HALF must be at least 2");
    end

    logic             rst_n_sync;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             clk_reg, clk_next;
    logic             pos_reg, pos_next;
    logic             neg_reg, neg_next;
    logic             wrap;

    gen_clk_rst_sync u_rst_sync (
        .clk_in     (clk_in),
        .resetN     (resetN),
        .rst_n_sync (rst_n_sync)
    );

    always_comb begin
        wrap     = (cnt_reg == CNT_MAX);
        cnt_next = cnt_reg + 1'b1;
        clk_next = clk_reg;
        pos_next = 1'b0;
        neg_next = 1'b0;
        if (wrap) begin
            cnt_next = '0;
            clk_next = ~clk_reg;
            // Strobe direction follows the level being entered.
            pos_next = ~clk_reg;
            neg_next = clk_reg;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            cnt_reg <= '0;
            clk_reg <= 1'b0;
            pos_reg <= 1'b0;
            neg_reg <= 1'b0;
        end else begin
            cnt_reg <= cnt_next;
            clk_reg <= clk_next;
            pos_reg <= pos_next;
            neg_reg <= neg_next;
        end
    end

    assign clk_out     = clk_reg;
    assign scl_posedge = pos_reg;
    assign scl_negedge = neg_reg;

`ifdef GEN_CLK_MID_EN
    localparam logic [CNT_W-1:0] MID_CNT = CNT_W'(HALF / 2 - 1);

    logic high_mid_reg;
    logic low_mid_reg;

    // Decode on the next-state values so the registered strobe lines up with
    // the cycle in which the counter actually holds MID_CNT.
    always_ff @(posedge clk_in or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            high_mid_reg <= 1'b0;
            low_mid_reg  <= 1'b0;
        end else begin
            high_mid_reg <= (cnt_next == MID_CNT) &&  clk_next;
            low_mid_reg  <= (cnt_next == MID_CNT) && !clk_next;
        end
    end

    assign scl_high_mid = high_mid_reg;
    assign scl_low_mid  = low_mid_reg;
`endif

endmodule

// File: tb/tb_gen_clk.sv
// tb_gen_clk
// Drives three gen_clk instances (HALF = 250, 2 and 62) from one 50 MHz
// clock and a shared reset. Outputs are compared every cycle with a model
// that derives the expected waveform from the number of clock edges seen
// since reset release; random run lengths and reset pulses exercise
// startup, steady state and mid-run reset.
`timescale 1ns/1ps
module tb_gen_clk;

    logic       clk;
    logic       resetN;
    logic [2:0] clk_o;
    logic [2:0] pos_o;
    logic [2:0] neg_o;
`ifdef GEN_CLK_MID_EN
    logic [2:0] hmid_o;
    logic [2:0] lmid_o;
`endif

    int h_arr [3];
    int n;
    int cyc;
    int last_pos [3];
    bit meas;
    int pass_cnt;
    int total_cnt;

    initial clk = 1'b0;
    always #10 clk = ~clk;

    gen_clk u_dut0 (
        .clk_in(clk), .resetN(resetN),
        .clk_out(clk_o[0]), .scl_posedge(pos_o[0]), .scl_negedge(neg_o[0])
`ifdef GEN_CLK_MID_EN
        , .scl_high_mid(hmid_o[0]), .scl_low_mid(lmid_o[0])
`endif
    );

    gen_clk #(.CLK_IN_HZ(50_000_000), .SCL_HZ(12_500_000)) u_dut1 (
        .clk_in(clk), .resetN(resetN),
        .clk_out(clk_o[1]), .scl_posedge(pos_o[1]), .scl_negedge(neg_o[1])
`ifdef GEN_CLK_MID_EN
        , .scl_high_mid(hmid_o[1]), .scl_low_mid(lmid_o[1])
`endif
    );

    gen_clk #(.CLK_IN_HZ(50_000_000), .SCL_HZ(400_000)) u_dut2 (
        .clk_in(clk), .resetN(resetN),
        .clk_out(clk_o[2]), .scl_posedge(pos_o[2]), .scl_negedge(neg_o[2])
`ifdef GEN_CLK_MID_EN
        , .scl_high_mid(hmid_o[2]), .scl_low_mid(lmid_o[2])
`endif
    );

    task automatic check(input string tag, input int obs, input int exp);
        total_cnt++;
        if (obs == exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Expected {low_mid, high_mid, negedge, posedge, clk_out} after the
    // n-th clock edge since release. Two edges go to the synchroniser; after
    // that every HALF edges the clock toggles.
    function automatic logic [4:0] model(input int h, input int edges);
        int t, tog, r;
        logic co;
        logic [4:0] res;
        res = '0;
        t   = edges - 2;
        if (t >= 1) begin
            tog = t / h;
            r   = t % h;
            co  = (tog % 2) == 1;
            res[0] = co;
            res[1] = (r == 0) &&  co;
            res[2] = (r == 0) && !co;
            res[3] = (r == h / 2 - 1) &&  co;
            res[4] = (r == h / 2 - 1) && !co;
        end
        return res;
    endfunction

    task automatic check_all();
        logic [4:0] e;
        for (int i = 0; i < 3; i++) begin
            e = model(h_arr[i], n);
            check($sformatf("clk_out[%0d]", i), int'(clk_o[i]), int'(e[0]));
            check($sformatf("scl_posedge[%0d]", i), int'(pos_o[i]), int'(e[1]));
            check($sformatf("scl_negedge[%0d]", i), int'(neg_o[i]), int'(e[2]));
`ifdef GEN_CLK_MID_EN
            check($sformatf("scl_high_mid[%0d]", i), int'(hmid_o[i]), int'(e[3]));
            check($sformatf("scl_low_mid[%0d]", i), int'(lmid_o[i]), int'(e[4]));
`endif
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        if (resetN) begin
            n++;
        end else begin
            n = 0;
            for (int i = 0; i < 3; i++) last_pos[i] = -1;
        end
        #1;
        check_all();
        for (int i = 0; i < 3; i++) begin
            if (neg_o[i] && meas && last_pos[i] >= 0)
                check($sformatf("high_width[%0d]", i), cyc - last_pos[i], h_arr[i]);
            if (pos_o[i]) begin
                if (meas && last_pos[i] >= 0)
                    check($sformatf("period[%0d]", i), cyc - last_pos[i], 2 * h_arr[i]);
                last_pos[i] = cyc;
            end
        end
    endtask

    // Called at 1 ns after an edge: assert reset between edges and confirm
    // the outputs clear without waiting for a clock.
    task automatic pulse_reset(input int hold);
        #4 resetN = 1'b0;
        #1;
        n = 0;
        for (int i = 0; i < 3; i++) last_pos[i] = -1;
        check_all();
        check("async_clear_clk_out", int'(clk_o[0]), 0);
        repeat (hold) step();
        #4 resetN = 1'b1;
    endtask

    task automatic check_first_rise(input string tag);
        repeat (251) step();
        check({tag, "_clk_before_252"}, int'(clk_o[0]), 0);
        step();
        check({tag, "_clk_at_252"}, int'(clk_o[0]), 1);
        check({tag, "_pos_at_252"}, int'(pos_o[0]), 1);
    endtask

    initial begin
        h_arr[0] = 50_000_000 / (2 * 100_000);
        h_arr[1] = 50_000_000 / (2 * 12_500_000);
        h_arr[2] = 50_000_000 / (2 * 400_000);
        n = 0; cyc = 0; meas = 0; pass_cnt = 0; total_cnt = 0;
        for (int i = 0; i < 3; i++) last_pos[i] = -1;

        resetN = 1'b0;
        #5;
        check_all();
        #10 resetN = 1'b1;
        check_first_rise("startup");
        $display("startup done at cycle %0d", cyc);

        meas = 1;
        repeat (5000) step();
        $display("steady state run done at cycle %0d", cyc);

        // Move to clk_out high with the counter at 100, then reset there.
        for (int k = 0; k < 600 && ((n - 2) % 500) != 350; k++) step();
        check("pre_reset_clk_high", int'(clk_o[0]), 1);
        pulse_reset(3);
        check_first_rise("restart");
        $display("mid-run reset done at cycle %0d", cyc);

        for (int ep = 0; ep < 6; ep++) begin
            int len;
            int hold;
            len  = $urandom_range(1500, 10);
            hold = $urandom_range(4, 1);
            repeat (len) step();
            pulse_reset(hold);
            $display("episode %0d: ran %0d cycles, reset held %0d", ep, len, hold);
        end
        repeat (1200) step();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/gen_clk.md
Name: gen_clk

Overview:
- Parameterised clock divider that derives a slow, 50%-duty serial clock (I2C-style SCL) from the fast system clock.
- Also emits single-cycle strobes marking each rising and falling edge of the divided clock.
- Sits between the system clock domain and a serial-bus master; the master uses the strobes as clock enables instead of clocking logic on clk_out.

Parameters:
- CLK_IN_HZ, 50_000_000, frequency of clk_in in Hz.
- SCL_HZ, 100_000, target frequency of clk_out in Hz.
- HALF (localparam), CLK_IN_HZ/(2*SCL_HZ) with integer truncation, clk_in cycles per clk_out half-period; default 250.
- CNT_W (localparam), $clog2(HALF), counter width.

Ports:
- clk_in  input  1  system clock; all logic on its rising edge.
- resetN  input  1  asynchronous active-low reset.
- clk_out  output  1  divided clock; 50% duty; period 2*HALF clk_in cycles.
- scl_posedge  output  1  one-cycle strobe, high in the first clk_in cycle in which clk_out is 1.
- scl_negedge  output  1  one-cycle strobe, high in the first clk_in cycle in which clk_out is 0.

Behaviour:
- Clocking and reset: one clock (clk_in); reset resetN is asynchronous, active-low.
- Reset values: cnt=0, clk_out=0, scl_posedge=0, scl_negedge=0.
- Each rising clk_in edge when not in reset:
  - If cnt==HALF-1: cnt<=0, clk_out<=~clk_out, scl_posedge<=~clk_out (old value), scl_negedge<=clk_out (old value).
  - Otherwise: cnt<=cnt+1, scl_posedge<=0, scl_negedge<=0.
- All outputs are registered; no combinational path from inputs.
- The strobe becomes visible on the same clk_in edge as the clk_out change.
- First clk_out rise and scl_posedge occur on the HALF-th rising clk_in edge after resetN deasserts; first fall is HALF edges later.
- scl_posedge and scl_negedge are never both high; each is high exactly 1 cycle per clk_out period.
- Frequency: actual clk_out = CLK_IN_HZ/(2*HALF). Non-integer ratios truncate (output slightly fast, never slow).
- Elaboration check: HALF>=2, else $fatal. At HALF==2 the strobes occupy alternate cycles.
- Counter wrap: cnt never exceeds HALF-1; no overflow state.
- Reset mid-operation: all outputs clear immediately (asynchronously). Any in-flight strobe is dropped; counting restarts from 0 after release.
- resetN deassertion is synchronised internally with a 2-flop synchroniser. This adds 2 cycles to the first-edge latency, so the first rise is on edge HALF+2.

Optional Feature:
- Macro GEN_CLK_MID_EN.
- Defined:
  - Adds outputs scl_high_mid and scl_low_mid (1 bit each).
  - Each is a one-cycle strobe when cnt==(HALF/2)-1 while clk_out is 1 (high_mid) or 0 (low_mid).
  - Marks the centre of each level, for sampling SDA / changing data.
  - Both reset to 0.
- Not defined: the ports and logic are absent; base behaviour unchanged.

Decomposition:
- Package gen_clk_pkg:
  - default constants CLK_IN_HZ_DEF=50_000_000 and SCL_HZ_DEF=100_000;
  - function calc_half(clk_hz, scl_hz) returning the half-period count.
- Reset synchroniser as sub-module gen_clk_rst_sync: async assert, sync deassert, 2 flops.
- Counter/toggle logic stays in gen_clk.

Test Plan:
- Reset and startup: 50 MHz clk_in (20 ns period), resetN low 10 ns then high -> clk_out=0 and strobes=0 during reset. First clk_out rise and scl_posedge on clk_in edge HALF+2=252 after release.
- Steady state: run 10 clk_out periods -> each period exactly 500 clk_in cycles (10 us); high and low each 250 cycles. Exactly one scl_posedge and one scl_negedge per period, each 1 cycle wide, coincident with the matching clk_out edge.
- Mid-run reset: assert resetN for 3 cycles while clk_out=1 at cnt=100 -> clk_out and strobes go 0 immediately without waiting for a clock. Restart timing identical to the startup case.
- Minimum divide: override SCL_HZ so HALF=2 -> clk_out toggles every 2 cycles. Strobes alternate posedge/negedge every 2 cycles, never simultaneous.
- Truncation: CLK_IN_HZ=50_000_000, SCL_HZ=400_000 -> HALF=62; measured period 124 cycles (2.48 us).
- GEN_CLK_MID_EN defined, default parameters -> scl_high_mid one cycle at cnt=124 while clk_out=1; scl_low_mid one cycle at cnt=124 while clk_out=0. With the macro undefined, the build has no such ports.
